// File: rtl/demux1t4_32_buf.sv
// demux1t4_32_buf: 1-to-4 word distributor with a single-entry holding
// register and an independent valid/ready handshake per output channel.
// A word presented with select s lands in channel s; a stalled consumer
// only blocks words aimed at its own channel.
module demux1t4_32_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] I,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  localparam int unsigned NCH = 4;

  logic [WIDTH-1:0] d_q [NCH];
  logic [WIDTH-1:0] d_d [NCH];
  logic [NCH-1:0]   v_q;
  logic [NCH-1:0]   v_d;
  logic [CNT_W-1:0] c_q [NCH];
  logic [CNT_W-1:0] c_d [NCH];
  logic             accept_c;

  // Target slot can take a word if empty or being drained this cycle.
  assign i_ready  = ~v_q[s] | o_ready[s];
  assign accept_c = i_valid & i_ready;

  // Per-channel next state: a fill wins over a same-cycle drain (no bubble).
  always_comb begin
    for (int k = 0; k < int'(NCH); k++) begin
      d_d[k] = d_q[k];
      v_d[k] = v_q[k];
      c_d[k] = c_q[k];
      if (accept_c && (s == 2'(k))) begin
        d_d[k] = I;
        v_d[k] = 1'b1;
        c_d[k] = c_q[k] + CNT_W'(1);
      end else if (v_q[k] && o_ready[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  // Channel registers with synchronous reset discarding any held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NCH); k++) begin
        d_q[k] <= '0;
        c_q[k] <= '0;
      end
      v_q <= '0;
    end else begin
      for (int k = 0; k < int'(NCH); k++) begin
        d_q[k] <= d_d[k];
        c_q[k] <= c_d[k];
      end
      v_q <= v_d;
    end
  end

  assign O0      = d_q[0];
  assign O1      = d_q[1];
  assign O2      = d_q[2];
  assign O3      = d_q[3];
  assign o_valid = v_q;
  assign cnt0    = c_q[0];
  assign cnt1    = c_q[1];
  assign cnt2    = c_q[2];
  assign cnt3    = c_q[3];

endmodule

// File: tb/tb_demux1t4_32_buf.sv
// Bench for demux1t4_32_buf: a slot-level model of the four channels is
// checked against the DUT on every falling edge, and directed scenarios
// pin hand-computed values. Counters are built 4 bits wide to reach wrap.
module tb_demux1t4_32_buf;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       s;
  logic [WIDTH-1:0] I;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] O0, O1, O2, O3;
  logic [3:0]       o_valid;
  logic [3:0]       o_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  int n_vec = 0;
  int n_err = 0;

  demux1t4_32_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s(s), .I(I), .i_valid(i_valid), .i_ready(i_ready),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .o_valid(o_valid), .o_ready(o_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel is a one-word slot; word count is total fills mod 16.
  bit          m_full [4];
  logic [31:0] m_word [4];
  int          m_fills [4];

  always @(posedge clk) begin
    bit took;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0; m_word[k] = 0; m_fills[k] = 0;
      end
    end else begin
      took = i_valid && (!m_full[s] || o_ready[s]);
      for (int k = 0; k < 4; k++)
        if (m_full[k] && o_ready[k]) m_full[k] = 0;
      if (took) begin
        m_full[s]  = 1;
        m_word[s]  = I;
        m_fills[s] = (m_fills[s] + 1) % 16;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = m_full[k];
    chk("m_i_ready", 32'(i_ready), 32'(!m_full[s] || o_ready[s]));
    chk("m_o_valid", 32'(o_valid), 32'(ev));
    chk("m_O0", O0, m_word[0]);
    chk("m_O1", O1, m_word[1]);
    chk("m_O2", O2, m_word[2]);
    chk("m_O3", O3, m_word[3]);
    chk("m_cnt0", 32'(cnt0), 32'(m_fills[0]));
    chk("m_cnt1", 32'(cnt1), 32'(m_fills[1]));
    chk("m_cnt2", 32'(cnt2), 32'(m_fills[2]));
    chk("m_cnt3", 32'(cnt3), 32'(m_fills[3]));
  end

  // Advance one clock: inputs set just after a falling edge, read at the next.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d);
    #1;
    i_valid = v; s = sel; I = d;
    #1;
  endtask

  task automatic pulse_rst();
    #1;
    rst = 1'b1; i_valid = 1'b0; o_ready = 4'b0000;
    cyc();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with a valid word pending for channel 2.
    rst = 1'b1; i_valid = 1'b1; I = 32'hDEADBEEF; s = 2'd2; o_ready = 4'b0000;
    cyc(); cyc();
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_O2", O2, 32'h0);
    chk("rst_cnt2", 32'(cnt2), 32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'h1);
    #1; rst = 1'b0;
    cyc();
    chk("post_rst_o_valid", 32'(o_valid), 32'h4);
    chk("post_rst_O2", O2, 32'hDEADBEEF);
    chk("post_rst_cnt2", 32'(cnt2), 32'h1);
    drive(1'b0, 2'd0, 32'h0);
    pulse_rst();

    // Streaming to all four channels with every consumer ready.
    o_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'(k + 1));
      chk("stream_i_ready", 32'(i_ready), 32'h1);
      cyc();
      chk("stream_o_valid", 32'(o_valid), 32'(1 << k));
    end
    chk("stream_O3", O3, 32'h4);
    drive(1'b0, 2'd0, 32'h0);
    cyc();
    chk("stream_idle", 32'(o_valid), 32'h0);
    chk("stream_cnt", {8'h0, 4'(cnt3), 4'(cnt2), 4'(cnt1), 4'(cnt0), 8'h0}, 32'h0011_1100);

    // Stall isolation: channel 0 stalled, retargeted word passes to 3.
    pulse_rst();
    o_ready = 4'b1110;
    drive(1'b1, 2'd0, 32'hA);
    cyc();
    chk("stall_O0_A", O0, 32'hA);
    drive(1'b1, 2'd0, 32'hB);
    chk("stall_i_ready_low", 32'(i_ready), 32'h0);
    cyc();
    chk("stall_O0_held", O0, 32'hA);
    drive(1'b1, 2'd3, 32'hC);
    chk("retarget_i_ready", 32'(i_ready), 32'h1);
    cyc();
    chk("retarget_o_valid", 32'(o_valid), 32'h9);
    chk("retarget_O3", O3, 32'hC);
    #1; o_ready = 4'b1111;
    drive(1'b1, 2'd0, 32'hB);
    chk("unstall_i_ready", 32'(i_ready), 32'h1);
    cyc();
    chk("unstall_O0_B", O0, 32'hB);
    chk("unstall_o_valid", 32'(o_valid), 32'h1);
    chk("unstall_cnt0", 32'(cnt0), 32'h2);
    drive(1'b0, 2'd0, 32'h0);
    cyc();

    // Simultaneous drain and fill on channel 1: no bubble.
    pulse_rst();
    drive(1'b1, 2'd1, 32'h11);
    cyc();
    chk("df_O1_first", O1, 32'h11);
    #1; o_ready = 4'b0010;
    drive(1'b1, 2'd1, 32'h22);
    chk("df_i_ready", 32'(i_ready), 32'h1);
    cyc();
    chk("df_o_valid", 32'(o_valid), 32'h2);
    chk("df_O1_second", O1, 32'h22);
    drive(1'b0, 2'd0, 32'h0);
    cyc();
    chk("df_drained", 32'(o_valid), 32'h0);

    // Counter wrap on channel 2.
    pulse_rst();
    o_ready = 4'b0100;
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 2'd2, 32'(32'h100 + j));
      cyc();
      if (j == 14) chk("wrap_cnt2_F", 32'(cnt2), 32'hF);
    end
    chk("wrap_cnt2_0", 32'(cnt2), 32'h0);
    chk("wrap_O2", O2, 32'h10F);
    chk("wrap_others", {20'h0, 4'(cnt0), 4'(cnt1), 4'(cnt3)}, 32'h0);
    drive(1'b0, 2'd0, 32'h0);
    cyc();

    // Reset in the middle of operation with all channels full and stalled.
    pulse_rst();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'(32'hF0 + k));
      cyc();
    end
    chk("full_o_valid", 32'(o_valid), 32'hF);
    chk("full_O1", O1, 32'hF1);
    #1; rst = 1'b1; i_valid = 1'b0;
    cyc();
    #1; rst = 1'b0;
    chk("midrst_o_valid", 32'(o_valid), 32'h0);
    chk("midrst_O", O0 | O1 | O2 | O3, 32'h0);
    chk("midrst_cnt", {16'h0, 4'(cnt0), 4'(cnt1), 4'(cnt2), 4'(cnt3)}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'(k), 32'h0);
      chk("midrst_i_ready", 32'(i_ready), 32'h1);
    end
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
